in_digit_capture: RTL and testbench

IN_DIGIT_CAPTURE -- requirements
Module: in_digit_capture

---
 rtl/in_digit_capture.sv | 184 ++++++++++++++++++
 tb/tb_in_digit_capture.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/in_digit_capture.sv
// rtl/in_digit_capture.sv - decimal entry of up to three digits via debounced buttons for the CPU IN instruction
module in_digit_capture #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_digit_raw,
  input  logic        btn_enter_raw,
  input  logic [3:0]  sw_data,
  input  logic        in_req,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        waiting,
  output logic [1:0]  digit_count,
  output logic [3:0]  bcd_uni,
  output logic [3:0]  bcd_dez,
  output logic [3:0]  bcd_cen,
  output logic        bad_digit
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  logic          dig_s1_q, dig_s1_d, dig_s2_q, dig_s2_d;
  logic          ent_s1_q, ent_s1_d, ent_s2_q, ent_s2_d;
  logic [3:0]    sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [CW-1:0] dig_cnt_q, dig_cnt_d, ent_cnt_q, ent_cnt_d;
  logic          dig_lvl_q, dig_lvl_d, ent_lvl_q, ent_lvl_d;
  logic          dig_press_q, dig_press_d, ent_press_q, ent_press_d;
  state_t        state_q, state_d;
  logic [9:0]    acc_q, acc_d;
  logic [1:0]    count_q, count_d;
  logic [3:0]    uni_q, uni_d, dez_q, dez_d, cen_q, cen_d;
  logic [31:0]   data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d;
  logic          waiting_q, waiting_d;
  logic          bad_digit_q, bad_digit_d;

  // Synchronise raw inputs, debounce each button and form a press pulse on a debounced rise
  always_comb begin
    dig_s1_d    = btn_digit_raw;
    dig_s2_d    = dig_s1_q;
    ent_s1_d    = btn_enter_raw;
    ent_s2_d    = ent_s1_q;
    sw_s1_d     = sw_data;
    sw_s2_d     = sw_s1_q;
    dig_cnt_d   = dig_cnt_q;
    dig_lvl_d   = dig_lvl_q;
    dig_press_d = 1'b0;
    ent_cnt_d   = ent_cnt_q;
    ent_lvl_d   = ent_lvl_q;
    ent_press_d = 1'b0;
    if (dig_s2_q == dig_lvl_q) begin
      dig_cnt_d = '0;
    end else if (dig_cnt_q == CNT_MAX) begin
      dig_cnt_d   = '0;
      dig_lvl_d   = ~dig_lvl_q;
      dig_press_d = ~dig_lvl_q;
    end else begin
      dig_cnt_d = dig_cnt_q + CW'(1);
    end
    if (ent_s2_q == ent_lvl_q) begin
      ent_cnt_d = '0;
    end else if (ent_cnt_q == CNT_MAX) begin
      ent_cnt_d   = '0;
      ent_lvl_d   = ~ent_lvl_q;
      ent_press_d = ~ent_lvl_q;
    end else begin
      ent_cnt_d = ent_cnt_q + CW'(1);
    end
  end

  // Entry FSM: enter wins over a simultaneous digit; outputs are precomputed for the next state
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    count_d      = count_q;
    uni_d        = uni_q;
    dez_d        = dez_q;
    cen_d        = cen_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    bad_digit_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_req) begin
          state_d = COLLECT;
          acc_d   = '0;
          count_d = '0;
          uni_d   = '0;
          dez_d   = '0;
          cen_d   = '0;
        end
      end
      COLLECT: begin
        if (ent_press_q) begin
          if (count_q != 2'd0) begin
            state_d      = DONE;
            data_out_d   = {22'b0, acc_q};
            data_valid_d = 1'b1;
          end else begin
            bad_digit_d = 1'b1;
          end
        end else if (dig_press_q) begin
          if (sw_s2_q <= 4'd9 && count_q != 2'd3) begin
            acc_d   = acc_q * 10'd10 + {6'b0, sw_s2_q};
            cen_d   = dez_q;
            dez_d   = uni_q;
            uni_d   = sw_s2_q;
            count_d = count_q + 2'd1;
          end else begin
            bad_digit_d = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    waiting_d = (state_d == COLLECT);
  end

  // State register with asynchronous clear of every flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig_s1_q     <= 1'b0;
      dig_s2_q     <= 1'b0;
      ent_s1_q     <= 1'b0;
      ent_s2_q     <= 1'b0;
      sw_s1_q      <= '0;
      sw_s2_q      <= '0;
      dig_cnt_q    <= '0;
      ent_cnt_q    <= '0;
      dig_lvl_q    <= 1'b0;
      ent_lvl_q    <= 1'b0;
      dig_press_q  <= 1'b0;
      ent_press_q  <= 1'b0;
      state_q      <= IDLE;
      acc_q        <= '0;
      count_q      <= '0;
      uni_q        <= '0;
      dez_q        <= '0;
      cen_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      waiting_q    <= 1'b0;
      bad_digit_q  <= 1'b0;
    end else begin
      dig_s1_q     <= dig_s1_d;
      dig_s2_q     <= dig_s2_d;
      ent_s1_q     <= ent_s1_d;
      ent_s2_q     <= ent_s2_d;
      sw_s1_q      <= sw_s1_d;
      sw_s2_q      <= sw_s2_d;
      dig_cnt_q    <= dig_cnt_d;
      ent_cnt_q    <= ent_cnt_d;
      dig_lvl_q    <= dig_lvl_d;
      ent_lvl_q    <= ent_lvl_d;
      dig_press_q  <= dig_press_d;
      ent_press_q  <= ent_press_d;
      state_q      <= state_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      uni_q        <= uni_d;
      dez_q        <= dez_d;
      cen_q        <= cen_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      waiting_q    <= waiting_d;
      bad_digit_q  <= bad_digit_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign waiting     = waiting_q;
  assign digit_count = count_q;
  assign bcd_uni     = uni_q;
  assign bcd_dez     = dez_q;
  assign bcd_cen     = cen_q;
  assign bad_digit   = bad_digit_q;

endmodule

// File: tb/tb_in_digit_capture.sv
// tb/tb_in_digit_capture.sv - scoreboard bench for in_digit_capture with DEBOUNCE_CYCLES=4
module tb_in_digit_capture;

  logic        clk;
  logic        reset;
  logic        btn_digit_raw;
  logic        btn_enter_raw;
  logic [3:0]  sw_data;
  logic        in_req;
  logic [31:0] data_out;
  logic        data_valid;
  logic        waiting;
  logic [1:0]  digit_count;
  logic [3:0]  bcd_uni;
  logic [3:0]  bcd_dez;
  logic [3:0]  bcd_cen;
  logic        bad_digit;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_bad;
    int unsigned value;
  } ev_t;

  ev_t exp_q[$];

  in_digit_capture #(.DEBOUNCE_CYCLES(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_digit_raw (btn_digit_raw),
    .btn_enter_raw (btn_enter_raw),
    .sw_data       (sw_data),
    .in_req        (in_req),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .waiting       (waiting),
    .digit_count   (digit_count),
    .bcd_uni       (bcd_uni),
    .bcd_dez       (bcd_dez),
    .bcd_cen       (bcd_cen),
    .bad_digit     (bad_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic push_data(input int unsigned v);
    ev_t e;
    e.is_bad = 1'b0;
    e.value  = v;
    exp_q.push_back(e);
  endtask

  task automatic push_bad();
    ev_t e;
    e.is_bad = 1'b1;
    e.value  = 0;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit dig, input bit ent, input int sw);
    sw_data = 4'(sw);
    step(2);
    btn_digit_raw = dig;
    btn_enter_raw = ent;
    step(10);
    btn_digit_raw = 1'b0;
    btn_enter_raw = 1'b0;
    step(10);
  endtask

  task automatic request();
    in_req = 1'b1;
    step(1);
    in_req = 1'b0;
    step(1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data_out"}, data_out, 0);
    check({tag, "_data_valid"}, data_valid, 0);
    check({tag, "_waiting"}, waiting, 0);
    check({tag, "_digit_count"}, digit_count, 0);
    check({tag, "_bcd"}, {bcd_cen, bcd_dez, bcd_uni}, 0);
    check({tag, "_bad_digit"}, bad_digit, 0);
  endtask

  // Monitor: every data_valid or bad_digit pulse must match the next queued expectation
  always @(negedge clk) begin : monitor
    ev_t e;
    if (!reset && (data_valid || bad_digit)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event data_valid=%0d bad_digit=%0d required none", data_valid, bad_digit);
      end else begin
        e = exp_q.pop_front();
        if (e.is_bad) begin
          check("bad_event", {data_valid, bad_digit}, 1);
        end else begin
          check("valid_event", {data_valid, bad_digit}, 2);
          check("valid_data_out", data_out, e.value);
          check("waiting_at_valid", waiting, 0);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    btn_digit_raw = 1'b0;
    btn_enter_raw = 1'b0;
    sw_data = 4'd0;
    in_req = 1'b0;
    step(3);
    check_zero("reset");
    reset = 1'b0;
    step(2);

    // 1,2,3 then enter -> 123
    request();
    check("collect_waiting", waiting, 1);
    press(1, 0, 1);
    press(1, 0, 2);
    press(1, 0, 3);
    check("count_3", digit_count, 3);
    check("bcd_123", {bcd_cen, bcd_dez, bcd_uni}, 12'h123);
    push_data(123);
    press(0, 1, 0);
    check("data_out_123", data_out, 123);
    check("waiting_after_done", waiting, 0);

    // short glitch rejected, clean press of 7 accepted once
    request();
    sw_data = 4'd7;
    step(2);
    btn_digit_raw = 1'b1;
    step(2);
    btn_digit_raw = 1'b0;
    step(10);
    check("glitch_count", digit_count, 0);
    press(1, 0, 7);
    check("clean_count", digit_count, 1);
    check("clean_uni", bcd_uni, 7);
    push_data(7);
    press(0, 1, 0);

    // 9,9,9 then a fourth digit is rejected
    request();
    press(1, 0, 9);
    press(1, 0, 9);
    press(1, 0, 9);
    push_bad();
    press(1, 0, 5);
    check("fourth_count", digit_count, 3);
    check("fourth_bcd", {bcd_cen, bcd_dez, bcd_uni}, 12'h999);
    push_data(999);
    press(0, 1, 0);
    check("data_out_999", data_out, 999);

    // empty enter, out-of-range digit, then 6 with simultaneous 4+enter
    request();
    push_bad();
    press(0, 1, 0);
    check("empty_enter_waiting", waiting, 1);
    push_bad();
    press(1, 0, 12);
    check("sw12_count", digit_count, 0);
    press(1, 0, 6);
    push_data(6);
    press(1, 1, 4);
    check("data_out_6", data_out, 6);
    check("simul_count", digit_count, 1);
    check("simul_uni", bcd_uni, 6);

    // asynchronous reset mid-entry, then a press without in_req
    request();
    press(1, 0, 3);
    press(1, 0, 8);
    check("pre_reset_count", digit_count, 2);
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    step(2);
    reset = 1'b0;
    step(2);
    press(1, 0, 5);
    check_zero("idle_press");

    // in_req during COLLECT keeps entry; idle presses after DONE leave data_out
    request();
    press(1, 0, 4);
    request();
    press(1, 0, 2);
    check("req_in_collect_count", digit_count, 2);
    check("req_in_collect_bcd", {bcd_dez, bcd_uni}, 8'h42);
    push_data(42);
    press(0, 1, 0);
    press(1, 0, 1);
    press(0, 1, 0);
    check("data_out_stable", data_out, 42);

    // button held through reset release counts as one press
    sw_data = 4'd5;
    btn_digit_raw = 1'b1;
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
    in_req = 1'b1;
    step(1);
    in_req = 1'b0;
    step(12);
    check("held_count", digit_count, 1);
    check("held_uni", bcd_uni, 5);
    btn_digit_raw = 1'b0;
    step(10);
    push_data(5);
    press(0, 1, 0);

    step(20);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
